// File: rtl/green_tracker.sv
// Purpose: tracks the bounding box of qualifying green pixels per frame and publishes its centre and pixel count.
// Latency: result_valid asserts two clk edges after the frame_end input cycle (one alignment stage + one publish register).
// Backpressure: none; pixel-rate streaming input, results are one-cycle pulses with held outputs.
//
// Ports:
//   clk, reset            - pixel clock, asynchronous active-high reset
//   greencheck            - green classification, arrives one clk after its pixel
//   pix_valid, x_in, y_in - active-area strobe and pixel coordinates
//   frame_end             - one-cycle end-of-frame pulse
//   centre_x, centre_y    - bounding-box centre of the last frame that met MIN_PIXELS
//   pix_count, found      - qualifying pixel count / threshold flag of the last completed frame
//   result_valid          - one-cycle pulse when the outputs above are refreshed
module green_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int RUN_LEN    = 4,
    parameter int MIN_PIXELS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       greencheck,
    input  logic       pix_valid,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic       frame_end,
    output logic [9:0]  centre_x,
    output logic [9:0]  centre_y,
    output logic [18:0] pix_count,
    output logic        found,
    output logic        result_valid
);

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    localparam logic [3:0]  RUN_LEN_L  = 4'(RUN_LEN);
    localparam logic [18:0] MIN_PIX_L  = 19'(MIN_PIXELS);
    localparam logic [18:0] CNT_MAX    = '1;
    localparam logic [9:0]  CX_RST     = 10'(H_ACTIVE / 2);
    localparam logic [9:0]  CY_RST     = 10'(V_ACTIVE / 2);
    localparam logic [9:0]  MIN_CLR    = 10'd1023;

    // Alignment stage: pixel strobe/coordinates delayed to meet their greencheck.
    logic       pv_dly_q,  pv_dly_d;
    logic [9:0] x_dly_q,   x_dly_d;
    logic [9:0] y_dly_q,   y_dly_d;
    logic       fe_dly_q,  fe_dly_d;

    state_t      state_q, state_d;
    logic [3:0]  run_q,   run_d;
    logic [18:0] cnt_q,   cnt_d;
    logic [9:0]  min_x_q, min_x_d;
    logic [9:0]  max_x_q, max_x_d;
    logic [9:0]  min_y_q, min_y_d;
    logic [9:0]  max_y_q, max_y_d;

    logic [9:0]  centre_x_q, centre_x_d;
    logic [9:0]  centre_y_q, centre_y_d;
    logic [18:0] pix_count_q, pix_count_d;
    logic        found_q, found_d;
    logic        result_valid_q, result_valid_d;

    // Per-pixel working values (this pixel already folded in).
    logic [3:0]  run_calc;
    logic        qualify;
    logic [18:0] cnt_upd;
    logic [9:0]  min_x_upd, max_x_upd, min_y_upd, max_y_upd;
    logic [10:0] sum_x, sum_y;

    always_comb begin
        pv_dly_d = pix_valid;
        x_dly_d  = x_in;
        y_dly_d  = y_in;
        fe_dly_d = frame_end;
    end

    always_comb begin
        // Run length including the current pixel; blanking and non-green both break the run,
        // and column 0 always starts a fresh run so nothing carries across rows.
        run_calc = 4'd0;
        if (pv_dly_q && greencheck) begin
            if (x_dly_q == 10'd0) begin
                run_calc = 4'd1;
            end else if (run_q >= RUN_LEN_L) begin
                run_calc = RUN_LEN_L;
            end else begin
                run_calc = run_q + 4'd1;
            end
        end

        qualify = (state_q == ACCUM) && pv_dly_q && greencheck && (run_calc == RUN_LEN_L);

        cnt_upd   = cnt_q;
        min_x_upd = min_x_q;
        max_x_upd = max_x_q;
        min_y_upd = min_y_q;
        max_y_upd = max_y_q;
        if (qualify) begin
            if (cnt_q != CNT_MAX) begin
                cnt_upd = cnt_q + 19'd1;
            end
            if (x_dly_q < min_x_q) min_x_upd = x_dly_q;
            if (x_dly_q > max_x_q) max_x_upd = x_dly_q;
            if (y_dly_q < min_y_q) min_y_upd = y_dly_q;
            if (y_dly_q > max_y_q) max_y_upd = y_dly_q;
        end

        // 11-bit sums so corner boxes (e.g. 603+639) cannot wrap.
        sum_x = {1'b0, min_x_upd} + {1'b0, max_x_upd};
        sum_y = {1'b0, min_y_upd} + {1'b0, max_y_upd};
    end

    always_comb begin
        state_d        = state_q;
        run_d          = run_q;
        cnt_d          = cnt_q;
        min_x_d        = min_x_q;
        max_x_d        = max_x_q;
        min_y_d        = min_y_q;
        max_y_d        = max_y_q;
        centre_x_d     = centre_x_q;
        centre_y_d     = centre_y_q;
        pix_count_d    = pix_count_q;
        found_d        = found_q;
        result_valid_d = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                // Partial frame after reset is ignored; first frame_end only aligns us.
                run_d = 4'd0;
                if (fe_dly_q) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (fe_dly_q) begin
                    // Publish uses the *_upd values so a pixel landing with frame_end counts.
                    pix_count_d    = cnt_upd;
                    found_d        = (cnt_upd >= MIN_PIX_L);
                    result_valid_d = 1'b1;
                    if (cnt_upd >= MIN_PIX_L) begin
                        centre_x_d = sum_x[10:1];
                        centre_y_d = sum_y[10:1];
                    end
                    run_d   = 4'd0;
                    cnt_d   = 19'd0;
                    min_x_d = MIN_CLR;
                    max_x_d = 10'd0;
                    min_y_d = MIN_CLR;
                    max_y_d = 10'd0;
                end else begin
                    run_d   = run_calc;
                    cnt_d   = cnt_upd;
                    min_x_d = min_x_upd;
                    max_x_d = max_x_upd;
                    min_y_d = min_y_upd;
                    max_y_d = max_y_upd;
                end
            end
            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_dly_q       <= 1'b0;
            x_dly_q        <= 10'd0;
            y_dly_q        <= 10'd0;
            fe_dly_q       <= 1'b0;
            state_q        <= WAIT_SYNC;
            run_q          <= 4'd0;
            cnt_q          <= 19'd0;
            min_x_q        <= MIN_CLR;
            max_x_q        <= 10'd0;
            min_y_q        <= MIN_CLR;
            max_y_q        <= 10'd0;
            centre_x_q     <= CX_RST;
            centre_y_q     <= CY_RST;
            pix_count_q    <= 19'd0;
            found_q        <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            pv_dly_q       <= pv_dly_d;
            x_dly_q        <= x_dly_d;
            y_dly_q        <= y_dly_d;
            fe_dly_q       <= fe_dly_d;
            state_q        <= state_d;
            run_q          <= run_d;
            cnt_q          <= cnt_d;
            min_x_q        <= min_x_d;
            max_x_q        <= max_x_d;
            min_y_q        <= min_y_d;
            max_y_q        <= max_y_d;
            centre_x_q     <= centre_x_d;
            centre_y_q     <= centre_y_d;
            pix_count_q    <= pix_count_d;
            found_q        <= found_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign centre_x     = centre_x_q;
    assign centre_y     = centre_y_q;
    assign pix_count    = pix_count_q;
    assign found        = found_q;
    assign result_valid = result_valid_q;

endmodule
